// File: rtl/mem_ctrl_pkg.sv
// Shared opcodes, FSM state type and port ids for the memory arbiter/controller.
package mem_ctrl_pkg;

    localparam logic [3:0] OP_LDR = 4'hA;
    localparam logic [3:0] OP_STR = 4'hB;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// Fetch/data request-response bus plus write-back mux signals of mem_arbiter_ctrl.
// d_err exists only when MEMCTL_RANGE_CHK_EN is defined.
interface mem_arbiter_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic [3:0]        d_opcode;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] reg_wdata;
`ifdef MEMCTL_RANGE_CHK_EN
    logic              d_err;

    modport master (
        output if_req, if_addr, d_req, d_opcode, d_addr, d_wdata, alu_result,
        input  if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata, reg_wdata, d_err
    );
    modport slave (
        input  if_req, if_addr, d_req, d_opcode, d_addr, d_wdata, alu_result,
        output if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata, reg_wdata, d_err
    );
`else
    modport master (
        output if_req, if_addr, d_req, d_opcode, d_addr, d_wdata, alu_result,
        input  if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata, reg_wdata
    );
    modport slave (
        input  if_req, if_addr, d_req, d_opcode, d_addr, d_wdata, alu_result,
        output if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata, reg_wdata
    );
`endif
endinterface

// File: rtl/mem_sp_ram.sv
// Synchronous single-port DEPTH x DATA_W RAM; registered read, contents not reset.
module mem_sp_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Round-robin fetch/data arbiter with wait-stated single-port RAM access and write-back mux.
// Optional range checking on data accesses: define MEMCTL_RANGE_CHK_EN.
module mem_arbiter_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    mem_arbiter_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    state_t            state, state_nxt;
    logic              last_grant;
    logic              port_q;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    logic              req_any, grant_port, accept;
    logic              if_ready_c, d_ready_c;
    logic              is_read, is_store, in_range;
    logic              ram_en;
    logic [DATA_W-1:0] ram_rdata, resp_data;
    logic              resp_if, resp_d;
    logic              unused_addr_bits;

    // Tie goes to the port that did not win last time.
    always_comb begin
        req_any    = bus.if_req | bus.d_req;
        grant_port = PORT_IF;
        if (bus.if_req && bus.d_req) begin
            grant_port = (last_grant == PORT_IF) ? PORT_D : PORT_IF;
        end else if (bus.d_req) begin
            grant_port = PORT_D;
        end
        accept     = (state == IDLE) && req_any;
        if_ready_c = accept && (grant_port == PORT_IF);
        d_ready_c  = accept && (grant_port == PORT_D);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_any) state_nxt = ACCESS;
            ACCESS:  if (cnt_q == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= PORT_IF;
            port_q     <= PORT_IF;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant_port;
                port_q     <= grant_port;
                op_q       <= bus.d_opcode;
                addr_q     <= (grant_port == PORT_D) ? bus.d_addr : bus.if_addr;
                wdata_q    <= bus.d_wdata;
                cnt_q      <= 4'(WAIT_CYCLES);
            end else if (state == ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (resp_if) if_rdata_q <= resp_data;
            if (resp_d)  d_rdata_q  <= resp_data;
        end
    end

`ifdef MEMCTL_RANGE_CHK_EN
    assign in_range = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));
`else
    assign in_range = 1'b1;
`endif
    assign unused_addr_bits = ^{1'b0, addr_q};

    assign is_read  = (port_q == PORT_IF) || (op_q == OP_LDR);
    assign is_store = (port_q == PORT_D) && (op_q == OP_STR);
    assign ram_en   = (state == ACCESS) && (cnt_q == '0) && in_range && (is_read || is_store);

    mem_sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (is_store),
        .addr  (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // RAM read register is not reset, so the visible rdata is muxed from it only during RESP
    // and otherwise held in resettable output registers.
    assign resp_data = (is_read && in_range) ? ram_rdata : '0;
    assign resp_if   = (state == RESP) && (port_q == PORT_IF);
    assign resp_d    = (state == RESP) && (port_q == PORT_D);

    assign bus.if_ready  = if_ready_c;
    assign bus.d_ready   = d_ready_c;
    assign bus.if_valid  = resp_if;
    assign bus.d_valid   = resp_d;
    assign bus.if_rdata  = resp_if ? resp_data : if_rdata_q;
    assign bus.d_rdata   = resp_d ? resp_data : d_rdata_q;
    assign bus.reg_wdata = (resp_d && op_q == OP_LDR) ? resp_data : bus.alu_result;
`ifdef MEMCTL_RANGE_CHK_EN
    assign bus.d_err     = resp_d && !in_range;
`endif

endmodule
